data_mem_responder: RTL

Synthesizable memory-side responder for the CPU data bus: it answers the read channel (`dr_addr` → `dr_data`) and the write channel (`dw_data_addr` → `dw_resp`) from an internal word array. Latency is programmable. It is the target end of the same valid/ready channels the CPU drives as initiator. It is used in simulation top levels and FPGA bring-up in place of an external data memory. One transaction is in flight at a time.

---
 rtl/data_mem_if.sv | 36 +++
 rtl/data_mem_responder.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/data_mem_if.sv
// Valid/ready data bus between the CPU (master) and a data memory (slave):
// a read request/data channel pair and a combined write address+data/response channel.
interface data_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    dr_addr_valid;
  logic                    dr_addr_ready;
  logic [ADDR_WIDTH-1:0]   dr_addr;
  logic                    dr_data_valid;
  logic                    dr_data_ready;
  logic [DATA_WIDTH-1:0]   dr_data;

  logic                    dw_data_addr_valid;
  logic                    dw_data_addr_ready;
  logic [ADDR_WIDTH-1:0]   dw_addr;
  logic [DATA_WIDTH-1:0]   dw_data;
  logic [DATA_WIDTH/8-1:0] dw_strobe;
  logic                    dw_resp_valid;
  logic                    dw_resp_ready;
  logic                    dw_resp;

  modport master (
    output dr_addr_valid, dr_addr, dr_data_ready,
           dw_data_addr_valid, dw_addr, dw_data, dw_strobe, dw_resp_ready,
    input  dr_addr_ready, dr_data_valid, dr_data,
           dw_data_addr_ready, dw_resp_valid, dw_resp
  );

  modport slave (
    input  dr_addr_valid, dr_addr, dr_data_ready,
           dw_data_addr_valid, dw_addr, dw_data, dw_strobe, dw_resp_ready,
    output dr_addr_ready, dr_data_valid, dr_data,
           dw_data_addr_ready, dw_resp_valid, dw_resp
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-array data memory answering the CPU data bus with programmable latency, one transaction at a time.
// Define DATA_MEM_MISALIGN_ERR_EN to flag accesses with addr[1:0] != 0 as errors.
module data_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int LATENCY    = 2
) (
  input logic        clk,
  input logic        rst,
  data_mem_if.slave  bus
);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [3:0] LAT = 4'(LATENCY);
`ifdef DATA_MEM_MISALIGN_ERR_EN
  localparam bit MISALIGN_ERR = 1'b1;
`else
  localparam bit MISALIGN_ERR = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP} state_t;

  state_t                state;
  logic                  rdy;
  logic [3:0]            cnt;
  logic                  rd_vld;
  logic                  wr_vld;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  resp;

  logic [IDX_W-1:0]      idx_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic                  mem_we;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Out of range when any bit above the word-index field is set (MEM_DEPTH is a power of two).
  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] addr);
    logic oor;
    oor = |addr[ADDR_WIDTH-1:IDX_W+2];
    return oor | (MISALIGN_ERR & (addr[1:0] != 2'b00));
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] addr);
    return addr[IDX_W+1:2];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] old_w,
                                                        input logic [DATA_WIDTH-1:0] new_w,
                                                        input logic [STRB_W-1:0]     strb);
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < STRB_W; i++)
      if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
    return res;
  endfunction

  // The write request always wins, so the read ready is masked by a pending write.
  assign bus.dw_data_addr_ready = rdy;
  assign bus.dr_addr_ready      = rdy & ~bus.dw_data_addr_valid;
  assign bus.dr_data_valid      = rd_vld;
  assign bus.dr_data            = rdata;
  assign bus.dw_resp_valid      = wr_vld;
  assign bus.dw_resp            = resp;

  assign mem_we = (state == WR_WAIT) && (cnt == 4'd0) && !err_q && !rst;

  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= merge_bytes(mem[idx_q], wdata_q, wstrb_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rdy    <= 1'b0;
      cnt    <= 4'd0;
      rd_vld <= 1'b0;
      wr_vld <= 1'b0;
      rdata  <= '0;
      resp   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rdy && bus.dw_data_addr_valid) begin
            rdy     <= 1'b0;
            cnt     <= LAT;
            idx_q   <= addr_idx(bus.dw_addr);
            err_q   <= addr_err(bus.dw_addr);
            wdata_q <= bus.dw_data;
            wstrb_q <= bus.dw_strobe;
            state   <= WR_WAIT;
          end else if (rdy && bus.dr_addr_valid) begin
            rdy   <= 1'b0;
            cnt   <= LAT;
            idx_q <= addr_idx(bus.dr_addr);
            err_q <= addr_err(bus.dr_addr);
            state <= RD_WAIT;
          end else begin
            rdy <= 1'b1;
          end
        end
        RD_WAIT: begin
          if (cnt == 4'd0) begin
            rdata  <= err_q ? '0 : mem[idx_q];
            rd_vld <= 1'b1;
            state  <= RD_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RD_RESP: begin
          if (bus.dr_data_ready) begin
            rd_vld <= 1'b0;
            rdy    <= 1'b1;
            state  <= IDLE;
          end
        end
        WR_WAIT: begin
          if (cnt == 4'd0) begin
            resp   <= err_q;
            wr_vld <= 1'b1;
            state  <= WR_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WR_RESP: begin
          if (bus.dw_resp_ready) begin
            wr_vld <= 1'b0;
            rdy    <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
